fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
// - Fetch/decode/sequence controller for the 16-entry x 16-bit program ROM.
// - Owns the program counter and drives the ROM address; latches each instruction word into an IR.
// - Resolves jmp, br and nop locally.
// - Hands all other opcodes (addi, sub, out, ...) to the datapath over a valid/ready handshake.
// - Watchdog faults the core if the datapath never accepts an instruction.
// PARAMETERS
// - ADDR_W    4        ROM address width; PC width.
// - DATA_W    16       Instruction width.
// - TIMEOUT   15       Max cycles exec_valid may wait for exec_ready before fault (1..255).
// - OP_NOP    4'b0000  Opcode handled locally: no operation.
// - OP_JMP    4'b1000  Opcode: unconditional jump to ir[11:8].
// - OP_BR     4'b1100  Opcode: jump to ir[11:8] if zero_flag, else fall through.
// PORTS
// - clk         in   1       System clock; all state updates on rising edge.
// - reset_n     in   1       Asynchronous, active-low reset.
// - run         in   1       1 = execute program; 0 = stop at next instruction boundary.
// - rom_addr    out  ADDR_W  ROM address; combinationally equal to pc.
// - rom_data    in   DATA_W  ROM instruction word (combinational ROM read).
// - zero_flag   in   1       Registered ALU zero flag from the datapath.
// - ir          out  DATA_W  Current instruction register.
// - pc          out  ADDR_W  Program counter.
// - exec_valid  out  1       Instruction in ir is offered to the datapath.
// - exec_ready  in   1       Datapath accepts/completes the instruction this cycle.
// - retire      out  1       1-cycle pulse per completed instruction (all opcodes).
// - busy        out  1       1 in any state except IDLE and FAULT.
// - fault       out  1       Sticky watchdog fault; cleared only by reset.
// BEHAVIOUR
// Reset values (async on reset_n=0):
// - state=IDLE, pc=0, ir=0, exec_valid=0, retire=0, fault=0, wdog=0.
// - An assertion mid-instruction aborts it immediately; exec_valid drops the same instant.
// States: IDLE, FETCH, DECODE, EXEC, FAULT.
// - IDLE: run=1 -> FETCH; otherwise stay. pc holds its value, so resume continues at the same address.
// - FETCH: ir <= rom_data (rom_addr=pc) -> DECODE.
// - DECODE: op = ir[15:12]; zero_flag is sampled this cycle.
//   - OP_JMP: pc <= ir[11:8]; retire=1.
//   - OP_BR: pc <= zero_flag ? ir[11:8] : pc+1; retire=1.
//   - OP_NOP: pc <= pc+1; retire=1.
//   - After any of these: next state FETCH if run, else IDLE.
//   - Any other op: exec_valid <= 1, wdog <= 0 -> EXEC.
// - EXEC: exec_valid held 1, ir and pc stable.
//   - exec_ready=1: exec_valid <= 0, pc <= pc+1, retire=1, next FETCH if run, else IDLE.
//   - exec_ready=0: wdog <= wdog+1.
//   - If wdog == TIMEOUT-1 with no ready: exec_valid <= 0, fault <= 1 -> FAULT.
// - FAULT: terminal; all handshake outputs 0; pc and ir frozen for debug.
// Timing and arithmetic:
// - PC increments are modulo 2^ADDR_W: 15+1 = 0.
// - Branch/jump target width is ADDR_W; upper target bits are ignored.
// - Latency: jmp/br/nop = 2 cycles (FETCH, DECODE).
// - Datapath op = 3 cycles minimum (exec_ready=1 on the first EXEC cycle), +1 per ready-low cycle.
// - run is sampled only at instruction boundaries; deasserting it never aborts a handshake in progress.
// - exec_ready while exec_valid=0 is ignored.
// - zero_flag changes outside DECODE have no effect.
// TESTING
// 1. Reset, run=1, exec_ready=1, ROM = addi,addi,addi,addi,sub at 0..4
//    -> pc = 0,1,2,3,4; each op has exec_valid high 1 cycle; retire every 3 cycles.
// 2. ROM[5]=br 8, zero_flag=1 at DECODE -> pc 5->8.
//    Repeat with zero_flag=0 -> pc 5->6.
// 3. ROM[7]=jmp 0 -> pc 7->0 after 2 cycles with exec_valid never asserted.
//    Program loops indefinitely.
// 4. exec_ready held 0 for 5 cycles, then 1 -> exec_valid high 6 cycles, one retire, no fault.
// 5. exec_ready held 0 with TIMEOUT=15 -> fault=1 after 15 EXEC cycles.
//    exec_valid=0; state frozen until reset_n pulse.
// 6. PC wrap: ROM[15] = out r7 -> pc 15->0.
//    Then reset_n low mid-EXEC -> exec_valid=0 and pc=0 immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/decode/sequence controller for a 16x16 program ROM
// Resolves nop/jmp/br locally; hands other opcodes to the datapath under a watchdog.
module fetch_sequencer #(
  parameter int          ADDR_W  = 4,
  parameter int          DATA_W  = 16,
  parameter int          TIMEOUT = 15,
  parameter logic [3:0]  OP_NOP  = 4'b0000,
  parameter logic [3:0]  OP_JMP  = 4'b1000,
  parameter logic [3:0]  OP_BR   = 4'b1100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              zero_flag,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] pc,
  output logic              exec_valid,
  input  logic              exec_ready,
  output logic              retire,
  output logic              busy,
  output logic              fault
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_exec_valid;
  logic              r_fault;
  logic [7:0]        r_wdog;

  logic [3:0]        w_op;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_local;
  logic              w_accept;
  logic [2:0]        w_boundary_state;

  assign w_op             = r_ir[DATA_W-1 -: 4];
  assign w_target         = r_ir[8 +: ADDR_W];
  assign w_pc_inc         = r_pc + 1'b1;
  assign w_local          = (w_op == OP_NOP) || (w_op == OP_JMP) || (w_op == OP_BR);
  assign w_accept         = (r_state == S_EXEC) && r_exec_valid && exec_ready;
  // run only matters once an instruction has fully completed
  assign w_boundary_state = run ? S_FETCH : S_IDLE;

  assign rom_addr   = r_pc;
  assign pc         = r_pc;
  assign ir         = r_ir;
  assign exec_valid = r_exec_valid;
  assign fault      = r_fault;
  assign retire     = ((r_state == S_DECODE) && w_local) || w_accept;
  assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_ir         <= '0;
      r_exec_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_wdog       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_ir    <= rom_data;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_local) begin
            if (w_op == OP_JMP)     r_pc <= w_target;
            else if (w_op == OP_BR) r_pc <= zero_flag ? w_target : w_pc_inc;
            else                    r_pc <= w_pc_inc;
            r_state <= w_boundary_state;
          end else begin
            r_exec_valid <= 1'b1;
            r_wdog       <= 8'd0;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exec_ready) begin
            r_exec_valid <= 1'b0;
            r_pc         <= w_pc_inc;
            r_state      <= w_boundary_state;
          end else if (r_wdog == 8'(TIMEOUT - 1)) begin
            r_exec_valid <= 1'b0;
            r_fault      <= 1'b1;
            r_state      <= S_FAULT;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        S_FAULT: begin
          r_state <= S_FAULT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
// An instruction-level program model predicts the retire stream; a monitor checks it.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        zero_flag = 1'b0;
  logic [15:0] ir;
  logic [3:0]  pc;
  logic        exec_valid;
  logic        exec_ready = 1'b0;
  logic        retire;
  logic        busy;
  logic        fault;

  logic [15:0] rom [16];
  assign rom_data = rom[rom_addr];

  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .zero_flag(zero_flag), .ir(ir), .pc(pc), .exec_valid(exec_valid),
    .exec_ready(exec_ready), .retire(retire), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pc;
    logic [15:0] ir;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   stall_q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   last_retire = 0;
  int   run_mode = 0;
  bit   hang = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // run source: off, on, or randomly toggling
  initial forever begin
    @(posedge clk);
    #1;
    if (run_mode == 2) run = ($urandom_range(0, 3) != 0);
    else               run = (run_mode == 1);
  end

  // datapath stand-in: stalls each offered op by the amount the model chose
  initial begin
    int  stall_cur;
    bit  prev_v;
    stall_cur = 0;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        exec_ready = 1'b0;
        prev_v = 1'b0;
      end else begin
        if (exec_valid && !prev_v)
          stall_cur = hang ? 1000000 : ((stall_q.size() != 0) ? stall_q.pop_front() : 0);
        if (exec_valid) begin
          if (stall_cur == 0) exec_ready = 1'b1;
          else begin
            exec_ready = 1'b0;
            stall_cur--;
          end
        end else begin
          exec_ready = 1'($urandom_range(0, 1));
        end
        prev_v = exec_valid;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (reset_n && retire) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("retire_pc", 32'(pc), 32'(e.pc));
        chk("retire_ir", 32'(ir), 32'(e.ir));
        if (e.lat != 0) chk("retire_latency", cyc - last_retire, e.lat);
      end
      last_retire = cyc;
    end
  end

  // instruction-level program execution starting at address 0
  task automatic build_model(input int n, input bit zf, input bit delta_ok);
    logic [3:0]  p;
    logic [3:0]  np;
    logic [15:0] w;
    int          lat;
    int          s;
    exp_t        e;
    p = 4'd0;
    for (int k = 0; k < n; k++) begin
      w = rom[p];
      case (w[15:12])
        4'h0: begin np = p + 4'd1; lat = 2; end
        4'h8: begin np = w[11:8]; lat = 2; end
        4'hC: begin np = zf ? w[11:8] : p + 4'd1; lat = 2; end
        default: begin
          s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
          stall_q.push_back(s);
          lat = 3 + s;
          np = p + 4'd1;
        end
      endcase
      e.pc = p;
      e.ir = w;
      e.lat = (k == 0 || !delta_ok) ? 0 : lat;
      sb.push_back(e);
      p = np;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    run_mode = 0;
    #1;
    chk("reset_exec_valid", 32'(exec_valid), 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_retire", 32'(retire), 0);
    chk("reset_ir", 32'(ir), 0);
    chk("reset_fault", 32'(fault), 0);
    chk("reset_busy", 32'(busy), 0);
    sb.delete();
    stall_q.delete();
    hang = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset(input int mode);
    @(negedge clk);
    reset_n = 1'b1;
    run_mode = mode;
  endtask

  task automatic run_phase(input int n, input bit zf, input bit toggle);
    int budget;
    do_reset();
    zero_flag = zf;
    build_model(n, zf, !toggle);
    release_reset(toggle ? 2 : 1);
    budget = n * 40 + 100;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("phase_drained", sb.size(), 0);
  endtask

  task automatic rand_rom();
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
  endtask

  task automatic spec_rom();
    rand_rom();
    rom[0] = 16'h1101; rom[1] = 16'h1202; rom[2] = 16'h1303; rom[3] = 16'h1404;
    rom[4] = 16'h2512; rom[5] = 16'hC800; rom[6] = 16'h0000; rom[7] = 16'h8000;
    rom[8] = 16'h3100; rom[9] = 16'h8000;
  endtask

  initial begin
    int vcnt;
    logic [3:0] pc_frozen;
    logic [15:0] ir_frozen;

    spec_rom();
    run_phase(20, 1'b1, 1'b0);
    spec_rom();
    run_phase(20, 1'b0, 1'b0);

    rand_rom();
    rom[0] = 16'h8F00;
    rom[15] = 16'h3700;
    run_phase(20, 1'($urandom_range(0, 1)), 1'b0);

    for (int ph = 0; ph < 8; ph++) begin
      rand_rom();
      run_phase(25, 1'($urandom_range(0, 1)), 1'(ph % 2));
    end

    // watchdog: three nops then a datapath op that is never accepted
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'h1111;
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000;
    build_model(3, 1'b0, 1'b1);
    hang = 1'b1;
    release_reset(1);
    vcnt = 0;
    for (int i = 0; i < 80 && !fault; i++) begin
      @(negedge clk);
      if (exec_valid) vcnt++;
    end
    chk("fault_set", 32'(fault), 1);
    chk("fault_valid_cycles", vcnt, 15);
    chk("fault_exec_valid", 32'(exec_valid), 0);
    chk("fault_busy", 32'(busy), 0);
    chk("fault_pc", 32'(pc), 3);
    pc_frozen = pc;
    ir_frozen = ir;
    repeat (10) @(negedge clk);
    chk("fault_sticky", 32'(fault), 1);
    chk("fault_pc_frozen", 32'(pc), 32'(pc_frozen));
    chk("fault_ir_frozen", 32'(ir), 32'(ir_frozen));
    chk("fault_no_retire", 32'(retire), 0);
    chk("fault_queue", sb.size(), 0);

    // reset asserted in the middle of a handshake
    do_reset();
    for (int i = 0; i < 16; i++) rom[i] = 16'h1111;
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000;
    build_model(3, 1'b0, 1'b1);
    hang = 1'b1;
    release_reset(1);
    vcnt = 0;
    for (int i = 0; i < 40 && !exec_valid; i++) @(negedge clk);
    chk("midexec_valid_seen", 32'(exec_valid), 1);
    repeat (4) @(negedge clk);
    chk("midexec_no_fault", 32'(fault), 0);
    chk("midexec_pc", 32'(pc), 3);
    reset_n = 1'b0;
    #1;
    chk("midexec_reset_valid", 32'(exec_valid), 0);
    chk("midexec_reset_pc", 32'(pc), 0);
    chk("midexec_reset_busy", 32'(busy), 0);
    hang = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
